bp_resolve: RTL

- Branch resolution and predictor-update stage paired with the 16-entry 1-bit branch-predictor table.
- Fetch side: supplies the table index, computes the predicted target, and forms the taken prediction.
- Tracks each in-flight predicted branch in a FIFO until the EX stage resolves it.
- On a mispredict: issues the single-cycle flip write to the predictor table, redirects fetch, and discards younger wrong-path entries.

---
 rtl/bp_resolve.sv | 112 +++++++++++
 1 files changed

// File: rtl/bp_resolve.sv
// Branch resolution stage: forms fetch-side predictions, tracks in-flight branches
// in a FIFO, and on a mispredict flips the predictor bit, redirects fetch and flushes.
module bp_resolve #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  input  logic [8:0]      if_offset,
  input  logic            if_pred,
  output logic [3:0]      pred_idx,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_taken,
  output logic            bp_we,
  output logic [3:0]      bp_waddr,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            q_full,
  output logic            q_empty,
  output logic            ovf,
  output logic            unf,
  output logic [15:0]     br_cnt,
  output logic [15:0]     mp_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
    logic [PC_W-1:0] tgt;
  } ent_t;

  ent_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic            bp_we_q, redirect_q, ovf_q, unf_q;
  logic [3:0]      bp_waddr_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic [15:0]     br_cnt_q, mp_cnt_q;

  logic [PC_W-1:0] off_sx;
  ent_t            head;
  logic            pop, mispredict, push, push_ok;

  assign off_sx      = {{(PC_W-9){if_offset[8]}}, if_offset};
  assign pred_idx    = if_pc[4:1];
  assign pred_taken  = if_valid & if_pred;
  assign pred_target = if_pc + PC_W'(2) + (off_sx << 1);

  assign q_empty = (cnt_q == '0);
  assign q_full  = (cnt_q == (AW+1)'(DEPTH));
  assign head    = mem_q[rd_ptr_q];

  assign pop        = ex_valid & ~stall & ~q_empty;
  assign mispredict = pop & (head.pred != ex_taken);
  assign push       = if_valid & ~stall & ~mispredict;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok    = push & (~q_full | pop);
  assign cnt_d      = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= '{pc: if_pc, pred: if_pred, tgt: pred_target};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      bp_we_q       <= 1'b0;
      bp_waddr_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      br_cnt_q      <= '0;
      mp_cnt_q      <= '0;
    end else begin
      bp_we_q    <= mispredict;
      redirect_q <= mispredict;
      if (mispredict) begin
        bp_waddr_q    <= head.pc[4:1];
        redirect_pc_q <= ex_taken ? head.tgt : head.pc + PC_W'(2);
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        cnt_q         <= '0;
        if (mp_cnt_q != 16'hFFFF) mp_cnt_q <= mp_cnt_q + 16'd1;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        cnt_q <= cnt_d;
      end
      if (pop && br_cnt_q != 16'hFFFF) br_cnt_q <= br_cnt_q + 16'd1;
      if (push && q_full && !pop)       ovf_q    <= 1'b1;
      if (ex_valid && !stall && q_empty) unf_q   <= 1'b1;
    end
  end

  assign bp_we       = bp_we_q;
  assign bp_waddr    = bp_waddr_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign ovf         = ovf_q;
  assign unf         = unf_q;
  assign br_cnt      = br_cnt_q;
  assign mp_cnt      = mp_cnt_q;
endmodule
